// File: rtl/trace_pkg.sv
// Shared definitions for the CPU trace capture block.
//   trace_state_e : capture FSM states (IDLE, ARMED, CAPTURE, DONE)
//   clog2_min1    : ceil(log2(value)), never less than 1 bit, for sizing
//                   index and select ports
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } trace_state_e;

  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Sample storage for the trace buffer: DEPTH x W simple dual-port RAM.
// One write port and one synchronous read port. Contents are not reset.
//   clk_i    : clock
//   we_i     : write enable, wdata_i stored at waddr_i
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable, rdata_o loads mem[raddr_i] on the next edge
//   raddr_i  : read address
//   rdata_o  : registered read data, holds while re_i is low
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 128,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_trace_capture.sv
// On-chip trace buffer for the multicycle MIPS CPU. Records NUM_CH probe
// channels per qualified cycle into a circular buffer with pre/post-trigger
// windowing and a masked-compare trigger on one selectable channel.
//   CLK, RST_n  : clock, asynchronous active-low reset
//   probe       : channel k at bits [k*CH_W +: CH_W]
//   sample_en   : probe is valid this cycle
//   arm / abort : start a capture / return to IDLE (abort wins)
//   trig_sel, trig_value, trig_mask : trigger fires when
//                 (ch[trig_sel] & mask) == (value & mask)
//   rd_en, rd_addr : readout request in DONE, rd_addr 0 = oldest sample
//   rd_data, rd_valid : registered readout, valid one cycle after rd_en
//   armed, done : status (ARMED|CAPTURE, DONE)
//   sample_cnt  : stored samples, saturating at DEPTH
//   trig_pos    : oldest-relative index of the trigger sample
//   dbg_state   : current FSM state
// Handshake: rd_en is a single-cycle request with no ready; when it is
// sampled in DONE, rd_valid is high for exactly the following cycle with the
// matching rd_data. Outside DONE rd_valid stays low and rd_data holds.
module cpu_trace_capture
  import trace_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CH_W    = 32,
  parameter int DEPTH   = 16,
  parameter int PRETRIG = 4,
  localparam int AW     = clog2_min1(DEPTH),
  localparam int SW     = clog2_min1(NUM_CH),
  localparam int DW     = NUM_CH * CH_W
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic [DW-1:0] probe,
  input  logic          sample_en,
  input  logic          arm,
  input  logic          abort,
  input  logic [SW-1:0] trig_sel,
  input  logic [CH_W-1:0] trig_value,
  input  logic [CH_W-1:0] trig_mask,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          armed,
  output logic          done,
  output logic [AW:0]   sample_cnt,
  output logic [AW-1:0] trig_pos,
  output logic [1:0]    dbg_state
);

  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_INIT = AW'(DEPTH - PRETRIG - 1);

  trace_state_e  state_q, state_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d, cnt_inc;
  logic [AW-1:0] post_q, post_d;
  logic [AW-1:0] trig_phys_q, trig_phys_d;
  logic [AW-1:0] trig_pos_q, trig_pos_d;
  logic [AW-1:0] oldest_q, oldest_d;
  logic          rd_valid_q;
  logic [DW-1:0] rd_hold_q;
  logic [DW-1:0] ram_rdata;
  logic          ram_we;
  logic          rd_fire;
  logic [CH_W-1:0] trig_ch;
  logic          trig_hit;

  // Channel select as a bounded mux so an out-of-range select reads zero.
  always_comb begin
    trig_ch = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (trig_sel == SW'(k)) begin
        trig_ch = probe[k*CH_W +: CH_W];
      end
    end
  end

  assign trig_hit = ((trig_ch ^ trig_value) & trig_mask) == '0;
  assign cnt_inc  = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + (AW+1)'(1);
  // Once the buffer has wrapped, the next write slot holds the oldest sample.
  assign oldest_q = (cnt_q == CNT_FULL) ? wr_q : '0;
  assign rd_fire  = rd_en && (state_q == DONE);

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    post_d      = post_q;
    trig_phys_d = trig_phys_q;
    trig_pos_d  = trig_pos_q;
    oldest_d    = '0;
    ram_we      = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            state_d = ARMED;
            wr_d    = '0;
            cnt_d   = '0;
            post_d  = POST_INIT;
          end
        end
        ARMED: begin
          if (sample_en) begin
            ram_we = 1'b1;
            wr_d   = wr_q + AW'(1);
            cnt_d  = cnt_inc;
            if (trig_hit) begin
              trig_phys_d = wr_q;
              state_d     = (post_q == '0) ? DONE : CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (sample_en) begin
            ram_we = 1'b1;
            wr_d   = wr_q + AW'(1);
            cnt_d  = cnt_inc;
            post_d = post_q - AW'(1);
            if (post_q == AW'(1)) begin
              state_d = DONE;
            end
          end
        end
        default: ;
      endcase
    end
    // Convert the physical trigger slot to an oldest-relative index once,
    // on the way into DONE, using the final pointer and count.
    if ((state_d == DONE) && (state_q != DONE)) begin
      oldest_d   = (cnt_d == CNT_FULL) ? wr_d : '0;
      trig_pos_d = trig_phys_d - oldest_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= IDLE;
      wr_q        <= '0;
      cnt_q       <= '0;
      post_q      <= '0;
      trig_phys_q <= '0;
      trig_pos_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_hold_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      post_q      <= post_d;
      trig_phys_q <= trig_phys_d;
      trig_pos_q  <= trig_pos_d;
      rd_valid_q  <= rd_fire;
      if (rd_valid_q) begin
        rd_hold_q <= ram_rdata;
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (DW),
    .AW    (AW)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .waddr_i (wr_q),
    .wdata_i (probe),
    .re_i    (rd_fire),
    .raddr_i (oldest_q + rd_addr),
    .rdata_o (ram_rdata)
  );

  // The RAM read register has no reset; rd_hold_q supplies the reset value
  // and keeps the last read visible between reads.
  assign rd_data    = rd_valid_q ? ram_rdata : rd_hold_q;
  assign rd_valid   = rd_valid_q;
  assign armed      = (state_q == ARMED) || (state_q == CAPTURE);
  assign done       = (state_q == DONE);
  assign sample_cnt = cnt_q;
  assign trig_pos   = trig_pos_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Bench for cpu_trace_capture: three instances (PRETRIG 2, 0, 7) share the
// same stimulus and are compared against a sample-log reference model.
module tb_cpu_trace_capture;

  localparam int DEPTH = 8;
  int pre_tab [3] = '{2, 0, 7};

  logic        CLK;
  logic        RST_n;
  logic [63:0] probe;
  logic        sample_en;
  logic        arm;
  logic        abort;
  logic        trig_sel;
  logic [31:0] trig_value;
  logic [31:0] trig_mask;
  logic        rd_en;
  logic [2:0]  rd_addr;

  logic [63:0] rd_data_w  [3];
  logic        rd_valid_w [3];
  logic        armed_w    [3];
  logic        done_w     [3];
  logic [3:0]  cnt_w      [3];
  logic [2:0]  tpos_w     [3];
  logic [1:0]  st_w       [3];

  int checks;
  int errors;

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  cpu_trace_capture #(.NUM_CH(2), .CH_W(32), .DEPTH(8), .PRETRIG(2)) u_p2 (
    .CLK(CLK), .RST_n(RST_n), .probe(probe), .sample_en(sample_en), .arm(arm),
    .abort(abort), .trig_sel(trig_sel), .trig_value(trig_value),
    .trig_mask(trig_mask), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_w[0]), .rd_valid(rd_valid_w[0]), .armed(armed_w[0]),
    .done(done_w[0]), .sample_cnt(cnt_w[0]), .trig_pos(tpos_w[0]),
    .dbg_state(st_w[0]));

  cpu_trace_capture #(.NUM_CH(2), .CH_W(32), .DEPTH(8), .PRETRIG(0)) u_p0 (
    .CLK(CLK), .RST_n(RST_n), .probe(probe), .sample_en(sample_en), .arm(arm),
    .abort(abort), .trig_sel(trig_sel), .trig_value(trig_value),
    .trig_mask(trig_mask), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_w[1]), .rd_valid(rd_valid_w[1]), .armed(armed_w[1]),
    .done(done_w[1]), .sample_cnt(cnt_w[1]), .trig_pos(tpos_w[1]),
    .dbg_state(st_w[1]));

  cpu_trace_capture #(.NUM_CH(2), .CH_W(32), .DEPTH(8), .PRETRIG(7)) u_p7 (
    .CLK(CLK), .RST_n(RST_n), .probe(probe), .sample_en(sample_en), .arm(arm),
    .abort(abort), .trig_sel(trig_sel), .trig_value(trig_value),
    .trig_mask(trig_mask), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_w[2]), .rd_valid(rd_valid_w[2]), .armed(armed_w[2]),
    .done(done_w[2]), .sample_cnt(cnt_w[2]), .trig_pos(tpos_w[2]),
    .dbg_state(st_w[2]));

  // ---------------- reference model ----------------
  // log_q holds every qualified sample ever presented; each instance records
  // where its capture started, how many samples it took, and which log entry
  // triggered. The buffer view is the last min(n, DEPTH) of those samples.
  logic [63:0] log_q [$];
  bit m_active [3];
  bit m_done   [3];
  int m_start  [3];
  int m_n      [3];
  int m_trig   [3];
  bit rv_exp   [3];

  function automatic int stored(int k);
    return (m_n[k] < DEPTH) ? m_n[k] : DEPTH;
  endfunction

  function automatic int oldest_abs(int k);
    return m_start[k] + m_n[k] - stored(k);
  endfunction

  function automatic bit model_hit(logic [63:0] p);
    logic [31:0] ch;
    ch = trig_sel ? p[63:32] : p[31:0];
    return (ch & trig_mask) == (trig_value & trig_mask);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_active[k] = 0; m_done[k] = 0; m_n[k] = 0; m_start[k] = 0;
      m_trig[k] = -1; rv_exp[k] = 0;
    end
  endtask

  task automatic model_step();
    int idx;
    for (int k = 0; k < 3; k++) begin
      rv_exp[k] = rd_en && m_done[k];
      if (abort) begin
        m_active[k] = 0;
        m_done[k]   = 0;
      end else if (!m_active[k]) begin
        if (arm) begin
          m_active[k] = 1; m_done[k] = 0; m_n[k] = 0;
          m_start[k] = log_q.size(); m_trig[k] = -1;
        end
      end else if (sample_en) begin
        idx = log_q.size();
        m_n[k]++;
        if (m_trig[k] < 0 && model_hit(probe)) m_trig[k] = idx;
        if (m_trig[k] >= 0 && (idx - m_trig[k]) == DEPTH - pre_tab[k] - 1) begin
          m_active[k] = 0;
          m_done[k]   = 1;
        end
      end
    end
    if (sample_en) log_q.push_back(probe);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input int k, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[inst%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk("armed", k, 64'(armed_w[k]), 64'(m_active[k]));
      chk("done", k, 64'(done_w[k]), 64'(m_done[k]));
      chk("sample_cnt", k, 64'(cnt_w[k]), 64'(stored(k)));
      chk("rd_valid", k, 64'(rd_valid_w[k]), 64'(rv_exp[k]));
      if (m_done[k]) chk("trig_pos", k, 64'(tpos_w[k]), 64'(m_trig[k] - oldest_abs(k)));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    if (RST_n) model_step();
    @(posedge CLK);
    #1;
    check_all();
    arm = 0; abort = 0; rd_en = 0;
  endtask

  task automatic sample(input bit se, input logic [31:0] c0, input logic [31:0] c1);
    sample_en = se;
    probe = {c1, c0};
    step();
  endtask

  task automatic read_all();
    bit dc [3];
    logic [63:0] ed [3];
    sample_en = 0;
    for (int a = 0; a < DEPTH; a++) begin
      for (int k = 0; k < 3; k++) begin
        dc[k] = m_done[k] && (a < stored(k));
        ed[k] = dc[k] ? log_q[oldest_abs(k) + a] : 64'd0;
      end
      rd_en = 1; rd_addr = 3'(a);
      step();
      for (int k = 0; k < 3; k++) begin
        if (dc[k]) chk("rd_data", k, rd_data_w[k], ed[k]);
      end
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    checks = 0; errors = 0;
    RST_n = 0; probe = '0; sample_en = 0; arm = 0; abort = 0;
    trig_sel = 0; trig_value = '0; trig_mask = '0; rd_en = 0; rd_addr = '0;
    model_reset();
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rst_rd_data", k, rd_data_w[k], 64'd0);
      chk("rst_state", k, 64'(st_w[k]), 64'd0);
    end
    check_all();
    @(posedge CLK); #1;
    RST_n = 1;

    // Basic: ch0 counts up, trigger on ch0 == 5.
    trig_sel = 0; trig_value = 32'd5; trig_mask = 32'hFFFF_FFFF;
    arm = 1; step();
    for (int i = 1; i <= 12; i++) begin
      sample(1, 32'(i), $urandom());
      if (i == 5) chk("p7_done_on_trig", 2, 64'(done_w[2]), 64'd1);
      if (i == 10) begin
        chk("basic_done", 0, 64'(done_w[0]), 64'd1);
        chk("basic_cnt", 0, 64'(cnt_w[0]), 64'd8);
        chk("basic_tpos", 0, 64'(tpos_w[0]), 64'd2);
      end
    end
    chk("p0_tpos", 1, 64'(tpos_w[1]), 64'd0);
    read_all();
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1; rd_addr = 3'(a); step();
      chk("basic_rd_ch0", 0, 64'(rd_data_w[0][31:0]), 64'(a + 3));
    end

    // PRETRIG = DEPTH-1 with a full buffer before the trigger.
    trig_value = 32'd20;
    arm = 1; step();
    for (int i = 11; i <= 27; i++) begin
      sample(1, 32'(i), $urandom());
      if (i == 20) begin
        chk("p7_full_cnt", 2, 64'(cnt_w[2]), 64'd8);
        chk("p7_full_tpos", 2, 64'(tpos_w[2]), 64'd7);
      end
    end
    read_all();

    // Early trigger: first sample matches.
    trig_value = 32'd5;
    arm = 1; step();
    for (int i = 5; i <= 12; i++) begin
      sample(1, 32'(i), $urandom());
      if (i == 10) begin
        chk("early_done", 0, 64'(done_w[0]), 64'd1);
        chk("early_cnt", 0, 64'(cnt_w[0]), 64'd6);
        chk("early_tpos", 0, 64'(tpos_w[0]), 64'd0);
      end
    end
    read_all();

    // Mask/select on channel 1; unqualified matching cycles never fire.
    trig_sel = 1; trig_value = 32'h00AB_0000; trig_mask = 32'h00FF_0000;
    arm = 1; step();
    for (int i = 0; i < 6; i++) begin
      sample(1, $urandom(), {8'h12, 8'($urandom_range(0, 8'hAA)), 16'h3456});
      sample(0, $urandom(), 32'h12AB_3456);
      chk("mask_still_armed", 0, 64'(st_w[0]), 64'd1);
    end
    sample(1, $urandom(), 32'h12AB_3456);
    chk("mask_fired", 0, 64'(st_w[0]), 64'd2);
    for (int i = 0; i < 8; i++) sample(1, $urandom(), 32'h0000_0000);
    read_all();

    // Arm/abort races.
    trig_sel = 0; trig_value = 32'd5; trig_mask = 32'hFFFF_FFFF;
    abort = 1; step();
    arm = 1; abort = 1; step();
    chk("arm_abort_idle", 0, 64'(st_w[0]), 64'd0);
    arm = 1; step();
    sample(1, 32'd5, 32'd0);
    arm = 1; sample(1, 32'd6, 32'd0);
    for (int i = 7; i <= 10; i++) sample(1, 32'(i), 32'd0);
    chk("arm_in_capture_done", 0, 64'(done_w[0]), 64'd1);
    read_all();
    arm = 1; step();
    chk("rearm_cnt", 0, 64'(cnt_w[0]), 64'd0);
    chk("rearm_armed", 0, 64'(armed_w[0]), 64'd1);
    abort = 1; step();

    // Asynchronous reset in the middle of a capture.
    arm = 1; step();
    for (int i = 1; i <= 6; i++) sample(1, 32'(i), $urandom());
    chk("pre_reset_capture", 0, 64'(st_w[0]), 64'd2);
    #2;
    RST_n = 0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("midrst_state", k, 64'(st_w[k]), 64'd0);
      chk("midrst_rd_data", k, rd_data_w[k], 64'd0);
    end
    check_all();
    sample_en = 0;
    step();
    RST_n = 1;
    rd_en = 1; rd_addr = 3'd0; step();

    // Randomized rounds: ch0 low-nibble trigger, random qualification.
    trig_sel = 0; trig_mask = 32'h0000_000F;
    for (int r = 0; r < 8; r++) begin
      trig_value = 32'($urandom_range(0, 15));
      arm = 1; step();
      for (int c = 0; c < 200; c++) begin
        if (!m_active[0] && !m_active[1] && !m_active[2]) break;
        if ($urandom_range(0, 60) == 0) abort = 1;
        sample($urandom_range(0, 3) != 0, $urandom(), $urandom());
      end
      if (m_active[0] || m_active[1] || m_active[2]) begin
        abort = 1; step();
      end
      read_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
